sparse_pack: RTL and testbench
==============================

Name: sparse_pack

Overview:
- Writer side of the sparse index/data memory pair: converts a dense vector stream into the compressed form walked by the index-compare datapath.
- For each nonzero element it writes the element position into an index RAM port and the value into a data RAM port, at consecutive addresses.
- After the last element it appends a sentinel index so the reader's compare/advance logic can detect end-of-list.
- One instance loads one vector; two instances load the two operand vectors.

Parameters:
- DATA_W, 8, width of element values and of index words.
- ADDR_W, 4, RAM address width; RAM depth = 2**ADDR_W.
- VEC_LEN, 16, dense elements per vector (1..2**DATA_W-1).
- SENTINEL, 8'hFF, index word written after the last packed entry.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  begin loading a vector; sampled in IDLE only.
- din_valid  in  1  dense element present on din.
- din  in  DATA_W  dense element value.
- din_ready  out  1  block accepts din this cycle.
- wr_en  out  1  write strobe, shared by index and data RAM ports.
- wr_addr  out  ADDR_W  write address, shared by index and data RAMs.
- idx_dout  out  DATA_W  index word to write (element position).
- val_dout  out  DATA_W  data word to write (element value).
- nnz  out  ADDR_W+1  count of nonzero entries packed, excluding the sentinel.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse at the end of a load.
- full  out  1  RAM exhausted; sentinel was dropped or entries were discarded.

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs 0; nnz=0.
  - State IDLE; element counter elem_cnt=0; write pointer wptr=0.
  - Asserting reset mid-load abandons the load. No further writes occur. RAM contents are left untouched.
- All outputs are registered.
- States:
  - IDLE: din_ready=0, busy=0. If start=1, go to STREAM next cycle, clear elem_cnt/wptr/nnz/full, and set busy=1.
  - STREAM: din_ready=1.
    - A transfer happens on din_valid&din_ready.
    - On a transfer with din!=0 and wptr<2**ADDR_W: next cycle wr_en=1, wr_addr=wptr, idx_dout=elem_cnt, val_dout=din. Then wptr++ and nnz++.
    - On a transfer with din!=0 and wptr==2**ADDR_W: no write; set full=1.
    - On a transfer with din==0: no write; only elem_cnt++.
    - Every transfer increments elem_cnt.
    - The transfer with elem_cnt==VEC_LEN-1 moves to TERM, and din_ready drops the following cycle.
    - din_valid=0 is a stall: no state change.
  - TERM: one cycle.
    - If wptr<2**ADDR_W: wr_en=1, wr_addr=wptr, idx_dout=SENTINEL, val_dout=0.
    - Otherwise: no write; set full=1.
    - nnz is not incremented.
    - Next state DONE.
  - DONE: done=1 for exactly one cycle; busy=0 from this cycle. Next state IDLE.
- Holding values:
  - wr_en is a one-cycle pulse per write.
  - wr_addr/idx_dout/val_dout hold their last values when wr_en=0.
  - nnz and full hold until the next accepted start.
- start while busy=1 is ignored.
- start in the DONE cycle is ignored; start must be issued again in IDLE.
- Latency:
  - Write appears 1 cycle after its accepting edge.
  - The sentinel write lands in the cycle after the last element's write slot.
  - done fires 2 cycles after the final transfer.
- Width rules:
  - elem_cnt is DATA_W bits and never reaches SENTINEL, since VEC_LEN<=2**DATA_W-1.
  - wptr is ADDR_W+1 bits so the full condition is representable; wr_addr = wptr[ADDR_W-1:0].
- Written indices are strictly increasing. This is the ordering the reader's compare logic requires.
- All-zero vector: only the sentinel is written at address 0; nnz=0.

Test Plan:
- Reset mid-STREAM after 5 transfers -> immediately busy=0, wr_en=0, nnz=0; next start restarts packing at wr_addr 0.
- Vector 0,3,0,0,7,0…0 (16 elements, din_valid held 1) -> writes (addr0: idx1,val3), (addr1: idx4,val7), (addr2: idx FF,val0); nnz=2; done pulses 2 cycles after the 16th transfer.
- All-zero vector -> single write at addr0 of idx FF/val0; nnz=0; full=0.
- All 16 elements nonzero (1..16) -> addr k holds idx k/val k+1 for k=0..15; sentinel dropped; nnz=16; full=1.
- din_valid toggled 1,0,0,1 pattern with values 9,x,x,2 -> writes only on transfer edges; stall cycles produce no wr_en and no elem_cnt advance; indices 0,1.
- start pulsed during STREAM and in the DONE cycle -> ignored; second load begins only on start in IDLE and overwrites from addr0.

Source files
------------

// File: rtl/sparse_pack.sv
// Sparse vector packer: turns a dense element stream into (index, value) pairs
// at consecutive RAM addresses, terminated by a sentinel index word.
module sparse_pack #(
  parameter int                 DATA_W   = 8,
  parameter int                 ADDR_W   = 4,
  parameter int                 VEC_LEN  = 16,
  parameter logic [DATA_W-1:0]  SENTINEL = DATA_W'(8'hFF)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              din_valid,
  input  logic [DATA_W-1:0] din,
  output logic              din_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] idx_dout,
  output logic [DATA_W-1:0] val_dout,
  output logic [ADDR_W:0]   nnz,
  output logic              busy,
  output logic              done,
  output logic              full
);

  localparam logic [DATA_W-1:0] LAST = DATA_W'(VEC_LEN - 1);

  typedef enum logic [1:0] {IDLE, STREAM, TERM, DONE} state_t;

  state_t              state, state_d;
  logic [DATA_W-1:0]   elem_cnt, elem_cnt_d;
  logic [ADDR_W:0]     wptr, wptr_d;
  logic                din_ready_d, wr_en_d, busy_d, done_d, full_d;
  logic [ADDR_W-1:0]   wr_addr_d;
  logic [DATA_W-1:0]   idx_d, val_d;
  logic [ADDR_W:0]     nnz_d;
  logic                xfer, room;

  assign xfer = din_valid & din_ready;
  // wptr MSB set means every RAM slot has been written
  assign room = ~wptr[ADDR_W];

  always_comb begin
    state_d     = state;
    elem_cnt_d  = elem_cnt;
    wptr_d      = wptr;
    din_ready_d = din_ready;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr;
    idx_d       = idx_dout;
    val_d       = val_dout;
    nnz_d       = nnz;
    busy_d      = busy;
    done_d      = 1'b0;
    full_d      = full;
    case (state)
      IDLE: if (start) begin
        state_d     = STREAM;
        din_ready_d = 1'b1;
        busy_d      = 1'b1;
        elem_cnt_d  = '0;
        wptr_d      = '0;
        nnz_d       = '0;
        full_d      = 1'b0;
      end
      STREAM: if (xfer) begin
        elem_cnt_d = elem_cnt + 1'b1;
        if (din != '0) begin
          if (room) begin
            wr_en_d   = 1'b1;
            wr_addr_d = wptr[ADDR_W-1:0];
            idx_d     = elem_cnt;
            val_d     = din;
            wptr_d    = wptr + 1'b1;
            nnz_d     = nnz + 1'b1;
          end else begin
            full_d = 1'b1;
          end
        end
        if (elem_cnt == LAST) begin
          state_d     = TERM;
          din_ready_d = 1'b0;
        end
      end
      TERM: begin
        if (room) begin
          wr_en_d   = 1'b1;
          wr_addr_d = wptr[ADDR_W-1:0];
          idx_d     = SENTINEL;
          val_d     = '0;
        end else begin
          full_d = 1'b1;
        end
        state_d = DONE;
        done_d  = 1'b1;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      elem_cnt  <= '0;
      wptr      <= '0;
      din_ready <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      idx_dout  <= '0;
      val_dout  <= '0;
      nnz       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      full      <= 1'b0;
    end else begin
      state     <= state_d;
      elem_cnt  <= elem_cnt_d;
      wptr      <= wptr_d;
      din_ready <= din_ready_d;
      wr_en     <= wr_en_d;
      wr_addr   <= wr_addr_d;
      idx_dout  <= idx_d;
      val_dout  <= val_d;
      nnz       <= nnz_d;
      busy      <= busy_d;
      done      <= done_d;
      full      <= full_d;
    end
  end

endmodule

// File: tb/tb_sparse_pack.sv
// Randomized bench for sparse_pack against a list-level packing model.
module tb_sparse_pack;

  logic       clk = 1'b0, reset = 1'b0, start = 1'b0, din_valid = 1'b0;
  logic [7:0] din = '0;
  logic       din_ready, wr_en, busy, done, full;
  logic [3:0] wr_addr;
  logic [7:0] idx_dout, val_dout;
  logic [4:0] nnz;

  sparse_pack dut (
    .clk(clk), .reset(reset), .start(start), .din_valid(din_valid), .din(din),
    .din_ready(din_ready), .wr_en(wr_en), .wr_addr(wr_addr), .idx_dout(idx_dout),
    .val_dout(val_dout), .nnz(nnz), .busy(busy), .done(done), .full(full)
  );

  typedef struct packed {
    logic [31:0] cyc;
    logic [3:0]  addr;
    logic [7:0]  idx;
    logic [7:0]  val;
  } wr_t;

  int   checks = 0, errors = 0, cyc = 0;
  wr_t  got_q[$], exp_q[$];
  int   tc[16];
  logic [7:0] vec[16];
  int   done_lat, exp_nnz;
  logic done2, exp_full;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (wr_en) got_q.push_back({32'(cyc), wr_addr, idx_dout, val_dout});

  // Expected RAM image: nonzeros in order, then the sentinel if a slot is left
  task automatic model();
    int n = 0;
    exp_q.delete();
    for (int i = 0; i < 16; i++)
      if (vec[i] != 0) begin
        if (n < 16) exp_q.push_back({32'(tc[i]), 4'(n), 8'(i), vec[i]});
        n++;
      end
    if (n < 16) exp_q.push_back({32'(tc[15] + 1), 4'(n), 8'hFF, 8'h00});
    exp_nnz  = (n < 16) ? n : 16;
    exp_full = (n >= 16);
  endtask

  // mode 0: valid held, 1: valid pattern 1,0,0,1, 2: random stalls
  task automatic drive(input int mode, input bit poke);
    int  i = 0, k = 0, guard = 0;
    logic xfer;
    got_q.delete();
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    while (i < 16 && guard < 500) begin
      case (mode)
        0:       din_valid = 1'b1;
        1:       din_valid = (k % 4 == 0) || (k % 4 == 3);
        default: din_valid = ($urandom_range(9) > 3);
      endcase
      din   = din_valid ? vec[i] : 8'($urandom_range(1, 255));
      start = poke && (i == 3);
      xfer  = din_valid && din_ready;
      @(posedge clk); #1; k++; guard++;
      if (xfer) begin tc[i] = cyc; i++; end
    end
    din_valid = 1'b0; start = 1'b0;
    done_lat = 1;
    while (!done && done_lat < 50) begin @(posedge clk); #1; done_lat++; end
    if (poke) start = 1'b1;
    @(posedge clk); #1 start = 1'b0; done2 = done;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks++; if ({wr_en, busy, done, full, din_ready} !== 5'b0) begin errors++;
      $display("FAIL reset_flags got %b want 00000", {wr_en, busy, done, full, din_ready}); end
    checks++; if (nnz !== 5'd0) begin errors++; $display("FAIL reset_nnz got %0d want 0", nnz); end
    checks++; if ({wr_addr, idx_dout, val_dout} !== 20'd0) begin errors++;
      $display("FAIL reset_data got %h want 0", {wr_addr, idx_dout, val_dout}); end
  endtask

  task automatic test_sparse();
    foreach (vec[i]) vec[i] = 8'd0;
    vec[1] = 8'd3; vec[4] = 8'd7;
    drive(0, 1'b0); model();
    checks++; if (got_q.size() !== 3) begin errors++; $display("FAIL sparse_count got %0d want 3", got_q.size()); end
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      checks++; if (got_q[k] !== exp_q[k]) begin errors++; $display("FAIL sparse_wr%0d got %h want %h", k, got_q[k], exp_q[k]); end
    end
    checks++; if (nnz !== 5'd2 || full !== 1'b0) begin errors++; $display("FAIL sparse_nnz got %0d/%b want 2/0", nnz, full); end
    checks++; if (done_lat !== 2 || done2 !== 1'b0) begin errors++;
      $display("FAIL sparse_done got lat %0d next %b want 2/0", done_lat, done2); end
  endtask

  task automatic test_all_zero();
    foreach (vec[i]) vec[i] = 8'd0;
    drive(0, 1'b0); model();
    checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL zero_count got %0d want 1", got_q.size()); end
    checks++; if (got_q.size() > 0 && got_q[0] !== exp_q[0]) begin errors++;
      $display("FAIL zero_sentinel got %h want %h", got_q[0], exp_q[0]); end
    checks++; if (nnz !== 5'd0 || full !== 1'b0) begin errors++; $display("FAIL zero_nnz got %0d/%b want 0/0", nnz, full); end
  endtask

  task automatic test_all_nonzero();
    foreach (vec[i]) vec[i] = 8'(i + 1);
    drive(0, 1'b0); model();
    checks++; if (got_q.size() !== 16) begin errors++; $display("FAIL dense_count got %0d want 16", got_q.size()); end
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      checks++; if (got_q[k] !== exp_q[k]) begin errors++; $display("FAIL dense_wr%0d got %h want %h", k, got_q[k], exp_q[k]); end
    end
    checks++; if (nnz !== 5'd16 || full !== 1'b1) begin errors++; $display("FAIL dense_nnz got %0d/%b want 16/1", nnz, full); end
    checks++; if (done_lat !== 2) begin errors++; $display("FAIL dense_done got %0d want 2", done_lat); end
  endtask

  task automatic test_stall();
    foreach (vec[i]) vec[i] = 8'd0;
    vec[0] = 8'd9; vec[1] = 8'd2;
    drive(1, 1'b0); model();
    checks++; if (got_q.size() !== exp_q.size()) begin errors++;
      $display("FAIL stall_count got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      checks++; if (got_q[k] !== exp_q[k]) begin errors++; $display("FAIL stall_wr%0d got %h want %h", k, got_q[k], exp_q[k]); end
    end
    checks++; if (nnz !== 5'd2) begin errors++; $display("FAIL stall_nnz got %0d want 2", nnz); end
  endtask

  task automatic test_start_ignored();
    foreach (vec[i]) vec[i] = ($urandom_range(1) == 1) ? 8'($urandom_range(1, 255)) : 8'd0;
    drive(0, 1'b1); model();
    checks++; if (got_q.size() !== exp_q.size()) begin errors++;
      $display("FAIL poke_count got %0d want %0d", got_q.size(), exp_q.size()); end
    checks++; if (busy !== 1'b0 || din_ready !== 1'b0) begin errors++;
      $display("FAIL poke_idle got busy %b rdy %b want 0/0", busy, din_ready); end
    foreach (vec[i]) vec[i] = 8'($urandom_range(1, 255));
    vec[2] = 8'd0;
    drive(0, 1'b0); model();
    checks++; if (got_q.size() !== exp_q.size()) begin errors++;
      $display("FAIL reload_count got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      checks++; if (got_q[k] !== exp_q[k]) begin errors++; $display("FAIL reload_wr%0d got %h want %h", k, got_q[k], exp_q[k]); end
    end
  endtask

  task automatic test_mid_reset();
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0; din_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin din = 8'(i + 1); @(posedge clk); #1; end
    din_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    checks++; if ({busy, wr_en, din_ready} !== 3'b0 || nnz !== 5'd0) begin errors++;
      $display("FAIL midrst got busy/wr/rdy %b nnz %0d want 000/0", {busy, wr_en, din_ready}, nnz); end
    got_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL midrst_writes got %0d want 0", got_q.size()); end
    foreach (vec[i]) vec[i] = ($urandom_range(3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
    vec[0] = 8'd5;
    drive(0, 1'b0); model();
    checks++; if (got_q.size() === 0 || got_q[0].addr !== 4'd0 || got_q[0].idx !== 8'd0) begin errors++;
      $display("FAIL midrst_restart got %0d writes first %h want addr0 idx0", got_q.size(), got_q.size() ? got_q[0] : '0); end
    checks++; if (nnz !== 5'(exp_nnz) || full !== exp_full) begin errors++;
      $display("FAIL midrst_nnz got %0d/%b want %0d/%b", nnz, full, exp_nnz, exp_full); end
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      int dens = $urandom_range(3);
      foreach (vec[i]) vec[i] = ($urandom_range(3) < dens + 1) ? 8'($urandom_range(1, 255)) : 8'd0;
      drive(2, 1'b0); model();
      checks++; if (got_q.size() !== exp_q.size()) begin errors++;
        $display("FAIL rnd%0d_count got %0d want %0d", r, got_q.size(), exp_q.size()); end
      for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
        checks++; if (got_q[k] !== exp_q[k]) begin errors++; $display("FAIL rnd%0d_wr%0d got %h want %h", r, k, got_q[k], exp_q[k]); end
      end
      checks++; if (nnz !== 5'(exp_nnz) || full !== exp_full || done_lat !== 2) begin errors++;
        $display("FAIL rnd%0d_end got %0d/%b lat %0d want %0d/%b lat 2", r, nnz, full, done_lat, exp_nnz, exp_full); end
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 test_reset();
    @(negedge clk) reset = 1'b1;
    test_mid_reset();
    test_sparse();
    test_all_zero();
    test_all_nonzero();
    test_stall();
    test_start_ignored();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
